// File: rtl/fusion_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fusion_pkg
// Description : Shared precision encodings and beat/slice helpers for the
//               brick fusion accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package fusion_pkg;

  // Operand precision encodings (prec == 3 behaves as 8-bit)
  localparam logic [1:0] PREC_2B = 2'd0;
  localparam logic [1:0] PREC_4B = 2'd1;
  localparam logic [1:0] PREC_8B = 2'd2;

  // Beat counter and shift-amount widths (16 beats max, shift 0..12)
  localparam int CNT_W   = 4;
  localparam int SHIFT_W = 4;

  // Number of brick partial products that make up one fused product
  function automatic logic [4:0] beats_per_op(input logic [1:0] prec);
    logic [4:0] beats;
    case (prec)
      PREC_2B: beats = 5'd1;
      PREC_4B: beats = 5'd4;
      default: beats = 5'd16;
    endcase
    return beats;
  endfunction

  // Number of 2-bit slices per operand
  function automatic logic [2:0] slices_per_op(input logic [1:0] prec);
    logic [2:0] slices;
    case (prec)
      PREC_2B: slices = 3'd1;
      PREC_4B: slices = 3'd2;
      default: slices = 3'd4;
    endcase
    return slices;
  endfunction

endpackage : fusion_pkg
`default_nettype wire

// File: rtl/fusion_slice_index.sv
`default_nettype none
// ============================================================================
// Module      : fusion_slice_index
// Description : Beat counter with latched precision. Derives the slice pair
//               (i, j) of the current beat, its shift amount 2*(i+j) and the
//               last-beat flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fusion_slice_index
  import fusion_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_adv,
  input  logic [1:0]         i_prec,
  output logic [CNT_W-1:0]   o_cnt,
  output logic [SHIFT_W-1:0] o_shamt,
  output logic               o_last
);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_prec;
  logic [1:0]       w_prec_eff;
  logic [2:0]       w_n;
  logic [1:0]       w_i;
  logic [1:0]       w_j;
  logic [2:0]       w_ij_sum;

  // The first beat uses the live prec; later beats use the latched copy
  assign w_prec_eff = (r_cnt == '0) ? i_prec : r_prec;
  assign w_n        = slices_per_op(w_prec_eff);

  // N is a power of two, so k / N and k % N are plain bit fields of cnt
  always_comb begin
    w_i = 2'd0;
    w_j = 2'd0;
    case (w_n)
      3'd1: begin
        w_i = 2'd0;
        w_j = 2'd0;
      end
      3'd2: begin
        w_i = {1'b0, r_cnt[1]};
        w_j = {1'b0, r_cnt[0]};
      end
      default: begin
        w_i = r_cnt[3:2];
        w_j = r_cnt[1:0];
      end
    endcase
  end

  assign w_ij_sum = {1'b0, w_i} + {1'b0, w_j};
  assign o_shamt  = {w_ij_sum, 1'b0};
  assign o_last   = ({1'b0, r_cnt} == (beats_per_op(w_prec_eff) - 5'd1));
  assign o_cnt    = r_cnt;

  // Advance on every accepted beat; wrap to zero on the last beat of an op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_prec <= PREC_2B;
    end else if (i_adv) begin
      if (r_cnt == '0) begin
        r_prec <= i_prec;
      end
      if (o_last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule : fusion_slice_index
`default_nettype wire

// File: rtl/brick_fusion_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : brick_fusion_accumulator
// Description : Shift-add accumulator that fuses a stream of signed 2x2 brick
//               partial products into one 2/4/8-bit product and hands it
//               downstream over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module brick_fusion_accumulator
  import fusion_pkg::*;
#(
  parameter int PP_W  = 4,
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PP_W-1:0]  pp,
  input  logic [1:0]       prec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
  output logic             busy
);

  localparam logic [0:0] C_ST_ACCUM = 1'b0;
  localparam logic [0:0] C_ST_HOLD  = 1'b1;

  logic [0:0]         r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   r_result;

  logic               w_accept;
  logic [CNT_W-1:0]   w_cnt;
  logic [SHIFT_W-1:0] w_shamt;
  logic               w_last;
  logic [ACC_W-1:0]   w_pp_ext;
  logic [ACC_W-1:0]   w_base;
  logic [ACC_W-1:0]   w_acc_next;

  // in_ready depends only on registered state, never on in_valid/out_ready
  assign in_ready  = (r_state == C_ST_ACCUM);
  assign out_valid = (r_state == C_ST_HOLD);
  assign w_accept  = in_valid && in_ready;
  assign busy      = (w_cnt != '0);
  assign result    = r_result;

  fusion_slice_index u_slice_index (
    .clk     (clk),
    .rst     (rst),
    .i_adv   (w_accept),
    .i_prec  (prec),
    .o_cnt   (w_cnt),
    .o_shamt (w_shamt),
    .o_last  (w_last)
  );

  // First beat starts from zero so no stale partial sum leaks in
  assign w_pp_ext   = {{(ACC_W-PP_W){pp[PP_W-1]}}, pp};
  assign w_base     = (w_cnt == '0) ? '0 : r_acc;
  assign w_acc_next = w_base + (w_pp_ext << w_shamt);

  // Accumulate in ACCUM, publish on the last beat, hold until taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= C_ST_ACCUM;
      r_acc    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        C_ST_ACCUM: begin
          if (w_accept) begin
            if (w_last) begin
              r_result <= w_acc_next;
              r_acc    <= '0;
              r_state  <= C_ST_HOLD;
            end else begin
              r_acc <= w_acc_next;
            end
          end
        end
        default: begin
          if (out_ready) begin
            r_state <= C_ST_ACCUM;
          end
        end
      endcase
    end
  end

endmodule : brick_fusion_accumulator
`default_nettype wire

// File: tb/tb_brick_fusion_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_brick_fusion_accumulator
// Description : Scoreboard bench: directed scenarios plus randomized ops,
//               expected products from a plain-arithmetic sum over slices.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_brick_fusion_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  pp;
  logic [1:0]  prec;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] result;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int ready_mode = 0;   // 0: always ready, 1: random, 2: driven by main

  logic [19:0] sb_q[$];
  logic [3:0]  s_pp[16];
  logic [1:0]  s_prec[16];

  brick_fusion_accumulator #(.PP_W(4), .ACC_W(20)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pp        (pp),
    .prec      (prec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int slices_of(input logic [1:0] p);
    return (p == 2'd0) ? 1 : (p == 2'd1) ? 2 : 4;
  endfunction

  // Product = sum over slice pairs of pp << 2*(i+j), modulo 2^20
  function automatic logic [19:0] model();
    int     n;
    longint acc;
    n   = slices_of(s_prec[0]);
    acc = 0;
    for (int k = 0; k < n * n; k++) begin
      acc += longint'($signed(s_pp[k])) * (longint'(1) << (2 * ((k / n) + (k % n))));
    end
    return acc[19:0];
  endfunction

  task automatic beat(input logic [3:0] v, input logic [1:0] p);
    int t;
    t = 0;
    in_valid = 1'b1;
    pp       = v;
    prec     = p;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      failures++;
      $display("FAIL accept_timeout actual=in_ready_low required=accept_within_200");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input int gapmax, input logic [19:0] exp);
    int n;
    n = slices_of(s_prec[0]) * slices_of(s_prec[0]);
    for (int k = 0; k < n; k++) begin
      if (gapmax > 0) begin
        repeat ($urandom_range(0, gapmax)) begin
          @(posedge clk);
          #1;
        end
      end
      beat(s_pp[k], s_prec[k]);
      if (k == n - 1) sb_q.push_back(exp);
      check("busy_after_beat", busy, (k != n - 1));
      check("out_valid_after_beat", out_valid, (k == n - 1));
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((out_valid || sb_q.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (out_valid || sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual=pending%0d required=0", sb_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Downstream ready generator
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) out_ready = 1'b1;
      else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: compares on each handshake, checks hold stability
  initial begin
    logic        prev_hold;
    logic [19:0] prev_res;
    prev_hold = 1'b0;
    prev_res  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          check("hold_valid", out_valid, 1'b1);
          check("hold_result", result, prev_res);
        end
        if (out_valid) check("in_ready_in_hold", in_ready, 1'b0);
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_result actual=%0h required=no_output", result);
          end else begin
            check("result", result, sb_q.pop_front());
          end
        end
        prev_hold = out_valid && !out_ready;
        prev_res  = result;
      end
    end
  end

  initial begin
    logic [19:0] e;
    rst      = 1'b1;
    in_valid = 1'b0;
    pp       = '0;
    prec     = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_result", result, 20'h0);
    check("reset_busy", busy, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // prec 0, single beat pp = 3
    s_pp[0] = 4'd3; s_prec[0] = 2'd0;
    run_op(0, 20'd3);
    check("p0_in_ready_hold", in_ready, 1'b0);
    @(posedge clk);
    #1;
    check("p0_in_ready_back", in_ready, 1'b1);
    check("p0_out_valid_drop", out_valid, 1'b0);

    // prec 1, all ones back to back
    for (int k = 0; k < 4; k++) begin s_pp[k] = 4'd1; s_prec[k] = 2'd1; end
    run_op(0, 20'd25);

    // prec 2, all -1 with random gaps
    for (int k = 0; k < 16; k++) begin s_pp[k] = 4'hF; s_prec[k] = 2'd2; end
    run_op(3, 20'(-7225));
    wait_idle();

    // Backpressure: out_ready low for 3 cycles
    ready_mode = 2;
    out_ready  = 1'b0;
    for (int k = 0; k < 4; k++) begin s_pp[k] = 4'($urandom); s_prec[k] = 2'd1; end
    e = model();
    run_op(0, e);
    repeat (3) begin
      check("stall_out_valid", out_valid, 1'b1);
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_result", result, e);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    pp        = 4'd5;
    prec      = 2'd0;
    @(posedge clk);
    #1;
    check("handshake_in_ready", in_ready, 1'b1);
    check("handshake_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sb_q.push_back(20'd5);
    check("next_beat_accepted", out_valid, 1'b1);
    ready_mode = 0;
    wait_idle();

    // prec changed mid-op is ignored
    s_pp[0] = 4'd2; s_pp[1] = 4'd0; s_pp[2] = 4'd0; s_pp[3] = 4'd1;
    s_prec[0] = 2'd1; s_prec[1] = 2'd1; s_prec[2] = 2'd0; s_prec[3] = 2'd0;
    run_op(0, 20'd18);
    wait_idle();

    // Reset in the middle of a prec 2 op
    for (int k = 0; k < 7; k++) beat(4'($urandom), 2'd2);
    check("pre_reset_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_result", result, 20'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    s_pp[0] = 4'hE; s_prec[0] = 2'd0;
    run_op(0, 20'hFFFFE);
    wait_idle();

    // Randomized ops with random backpressure and gaps
    ready_mode = 1;
    for (int op = 0; op < 30; op++) begin
      for (int k = 0; k < 16; k++) begin
        s_pp[k]   = 4'($urandom);
        s_prec[k] = 2'($urandom_range(0, 3));
      end
      run_op(2, model());
    end
    ready_mode = 0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_brick_fusion_accumulator
`default_nettype wire
